// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct
// Purpose  : Direct-mapped instruction cache. It sits between the fetcher and
//            the instruction port of the memory controller. Each line holds
//            one 32-bit word. A hit returns the word one cycle after the
//            request. A miss fetches the word from memory, fills the line and
//            then returns the word.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            rdy                 - global ready; low freezes all state
//            in_fetch_req/pc     - fetch request (pc[1:0] ignored)
//            out_fetch_ready     - a request can be accepted this cycle
//            out_fetch_valid     - one-cycle pulse, out_fetch_instr is valid
//            out_fetch_instr     - returned instruction
//            out_mem_get_instr   - level request to the memory controller
//            out_mem_address     - word-aligned fetch address
//            in_mem_get_instr    - one-cycle pulse, in_mem_instr is valid
//            in_mem_instr        - word returned by memory
//            in_misbranch        - abandon the pending request
//            out_hit_count/out_miss_count (ICACHE_STATS_EN only)
// Options  : ICACHE_STATS_EN - adds the hit and miss counters
// Revision : 1.0 - initial release
// ============================================================================
module icache_direct #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        in_fetch_req,
   input  logic [31:0] in_fetch_pc,
   output logic        out_fetch_ready,
   output logic        out_fetch_valid,
   output logic [31:0] out_fetch_instr,
   output logic        out_mem_get_instr,
   output logic [31:0] out_mem_address,
   input  logic        in_mem_get_instr,
   input  logic [31:0] in_mem_instr,
   input  logic        in_misbranch
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] out_hit_count,
   output logic [31:0] out_miss_count
`endif
);

   localparam int c_lines = 1 << INDEX_BITS;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MISS = 1'b1
   } state_t;

   state_t              r_state;
   logic [31:0]         r_pending_pc;
   logic                r_fetch_valid;
   logic [31:0]         r_fetch_instr;
   logic                r_mem_get_instr;
   logic [c_lines-1:0]  r_valid;
   logic [TAG_BITS-1:0] r_tag  [c_lines];
   logic [31:0]         r_data [c_lines];

   logic [INDEX_BITS-1:0] w_req_idx;
   logic [TAG_BITS-1:0]   w_req_tag;
   logic [INDEX_BITS-1:0] w_pend_idx;
   logic [TAG_BITS-1:0]   w_pend_tag;
   logic                  w_hit;
   logic                  w_accept;
   logic                  w_fill;
   logic [1:0]            w_unused_pc_bits;

   assign w_req_idx        = in_fetch_pc[INDEX_BITS+1:2];
   assign w_req_tag        = in_fetch_pc[31:INDEX_BITS+2];
   assign w_pend_idx       = r_pending_pc[INDEX_BITS+1:2];
   assign w_pend_tag       = r_pending_pc[31:INDEX_BITS+2];
   assign w_unused_pc_bits = in_fetch_pc[1:0] | r_pending_pc[1:0];

   // The tag is compared against the array combinationally in the accept
   // cycle, so a hit can be answered on the very next edge.
   assign w_hit    = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
   assign w_accept = in_fetch_req && (r_state == S_IDLE) && !in_misbranch;
   // A fill is written even when it coincides with a misbranch. The address
   // is genuine, so the line is usable; only the forwarding is dropped.
   assign w_fill   = (r_state == S_MISS) && in_mem_get_instr;

   assign out_fetch_ready   = (r_state == S_IDLE);
   assign out_fetch_valid   = r_fetch_valid;
   assign out_fetch_instr   = r_fetch_instr;
   assign out_mem_get_instr = r_mem_get_instr;
   assign out_mem_address   = r_pending_pc;

   // Tag and data storage is not reset. The valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (!rst && rdy && w_fill) begin
         r_tag[w_pend_idx]  <= w_pend_tag;
         r_data[w_pend_idx] <= in_mem_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_pending_pc    <= 32'd0;
         r_fetch_valid   <= 1'b0;
         r_fetch_instr   <= 32'd0;
         r_mem_get_instr <= 1'b0;
         r_valid         <= '0;
`ifdef ICACHE_STATS_EN
         out_hit_count   <= 32'd0;
         out_miss_count  <= 32'd0;
`endif
      end else if (rdy) begin
         r_fetch_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_pending_pc <= {in_fetch_pc[31:2], 2'b00};
                  if (w_hit) begin
                     r_fetch_valid <= 1'b1;
                     r_fetch_instr <= r_data[w_req_idx];
                  end else begin
                     r_state         <= S_MISS;
                     r_mem_get_instr <= 1'b1;
                  end
               end
            end
            S_MISS: begin
               if (w_fill) begin
                  r_valid[w_pend_idx] <= 1'b1;
                  if (!in_misbranch) begin
                     r_fetch_valid <= 1'b1;
                     r_fetch_instr <= in_mem_instr;
                  end
               end
               if (w_fill || in_misbranch) begin
                  r_state         <= S_IDLE;
                  r_mem_get_instr <= 1'b0;
               end
            end
            default: begin
               r_state         <= S_IDLE;
               r_mem_get_instr <= 1'b0;
            end
         endcase
`ifdef ICACHE_STATS_EN
         // A miss is counted when it is accepted, so a miss that is later
         // abandoned by a misbranch still shows up in the count.
         if (w_accept && w_hit)
            out_hit_count <= out_hit_count + 32'd1;
         if (w_accept && !w_hit)
            out_miss_count <= out_miss_count + 32'd1;
`endif
      end
   end

endmodule
`default_nettype wire
